// File: rtl/seg_scan_ctrl.sv
// Scan controller for an 8-digit multiplexed seven-segment display.
// Host writes go to a shadow bank, which is committed at frame boundaries. Define SEG_LZB_EN to enable leading-zero blanking.
module seg_scan_ctrl #(
    parameter int DWELL     = 50000,
    parameter int BLANK_CYC = 4,
    parameter int CNT_W     = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scan_en,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [2:0] wr_addr,
    input  logic [3:0] wr_data,
    output logic [7:0] digit_n,
    output logic [3:0] nibble,
    output logic [2:0] scan_idx,
    output logic       frame_done
);

    // state | meaning
    // IDLE  | display dark, scan_idx held at 0, pending shadow copied to display
    // BLANK | all digits off between digit slots, BLANK_CYC cycles
    // DRIVE | digit scan_idx enabled for DWELL cycles
    typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

    localparam logic [CNT_W-1:0] ONE      = 1;
    localparam logic [CNT_W-1:0] DWELL_LD = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] BLANK_LD = CNT_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
    localparam bit               NO_BLANK = (BLANK_CYC == 0);

    state_t           state;
    state_t           nxt_state;
    logic [CNT_W-1:0] timer;
    logic [CNT_W-1:0] nxt_timer;
    logic [2:0]       nxt_idx;
    logic [7:0][3:0]  shadow;
    logic [7:0][3:0]  display;
    logic [7:0][3:0]  nxt_shadow;
    logic [7:0][3:0]  nxt_display;
    logic             dirty;
    logic             nxt_dirty;
    logic             frame_end;
    logic             commit_next;
    logic             wr_fire;
    logic [7:0]       suppress;

    assign wr_fire = wr_valid & wr_ready;

    always_comb begin
        nxt_state   = state;
        nxt_timer   = timer;
        nxt_idx     = scan_idx;
        nxt_shadow  = shadow;
        nxt_display = display;
        nxt_dirty   = dirty;
        frame_end   = 1'b0;

        case (state)
            IDLE: begin
                nxt_idx   = 3'd0;
                nxt_timer = '0;
                if (scan_en) begin
                    nxt_state = NO_BLANK ? DRIVE : BLANK;
                    nxt_timer = NO_BLANK ? DWELL_LD : BLANK_LD;
                end
            end
            BLANK: begin
                if (timer == '0) begin
                    nxt_state = DRIVE;
                    nxt_timer = DWELL_LD;
                end else begin
                    nxt_timer = timer - ONE;
                end
            end
            DRIVE: begin
                if (timer == '0) begin
                    nxt_idx   = scan_idx + 3'd1;
                    nxt_state = NO_BLANK ? DRIVE : BLANK;
                    nxt_timer = NO_BLANK ? DWELL_LD : BLANK_LD;
                    frame_end = (scan_idx == 3'd7);
                end else begin
                    nxt_timer = timer - ONE;
                end
            end
            default: nxt_state = IDLE;
        endcase

        // Losing scan_en aborts the frame; the partial frame never commits.
        if (state != IDLE && !scan_en) begin
            nxt_state = IDLE;
            nxt_timer = '0;
            nxt_idx   = 3'd0;
            frame_end = 1'b0;
        end

        if (dirty && (state == IDLE || frame_end)) begin
            nxt_display = shadow;
            nxt_dirty   = 1'b0;
        end

        if (wr_fire) begin
            nxt_shadow[wr_addr] = wr_data;
            nxt_dirty           = 1'b1;
        end
    end

    // wr_ready is registered, so the commit cycle must be predicted one cycle early.
    assign commit_next = (nxt_state == DRIVE) && (nxt_idx == 3'd7) && (nxt_timer == '0);

`ifdef SEG_LZB_EN
    logic lzb_zeros;

    always_comb begin
        suppress  = '0;
        lzb_zeros = 1'b1;
        for (int k = 7; k >= 1; k--) begin
            lzb_zeros   = lzb_zeros && (nxt_display[k] == 4'd0);
            suppress[k] = lzb_zeros;
        end
    end
`else
    assign suppress = '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            timer      <= '0;
            scan_idx   <= 3'd0;
            shadow     <= '0;
            display    <= '0;
            dirty      <= 1'b0;
            digit_n    <= 8'hFF;
            nibble     <= 4'd0;
            frame_done <= 1'b0;
            wr_ready   <= 1'b1;
        end else begin
            state      <= nxt_state;
            timer      <= nxt_timer;
            scan_idx   <= nxt_idx;
            shadow     <= nxt_shadow;
            display    <= nxt_display;
            dirty      <= nxt_dirty;
            frame_done <= frame_end;
            wr_ready   <= !commit_next;
            nibble     <= nxt_display[nxt_idx];
            digit_n    <= (nxt_state == DRIVE && !suppress[nxt_idx]) ? ~(8'd1 << nxt_idx) : 8'hFF;
        end
    end

endmodule
